// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
//   Collects completed results from the memory unit and the ALU, holds them
//   in an in-order circular FIFO, and drains one entry per cycle into the
//   register-file write port. Queued values that have not yet been written
//   can be looked up by decode through two forwarding ports.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   mem_valid/dest/data, ready   memory-unit result handshake (older producer)
//   alu_valid/dest/data, ready   ALU result handshake (younger producer)
//   rf_load, rf_dest, rf_in      regfile write port, driven from the head entry
//   src_a/b, fwd_*_hit/data      forwarding lookup, youngest match wins
//   count                        number of occupied entries
module rf_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   input  logic [4:0]               mem_dest,
   input  logic [31:0]              mem_data,
   output logic                     mem_ready,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_dest,
   input  logic [31:0]              alu_data,
   output logic                     alu_ready,
   output logic                     rf_load,
   output logic [4:0]               rf_dest,
   output logic [31:0]              rf_in,
   input  logic [4:0]               src_a,
   input  logic [4:0]               src_b,
   output logic                     fwd_a_hit,
   output logic [31:0]              fwd_a_data,
   output logic                     fwd_b_hit,
   output logic [31:0]              fwd_b_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic [4:0]    dest_q [DEPTH];
   logic [31:0]   data_q [DEPTH];

   logic          mem_push;
   logic          alu_push;
   logic          pop;
   logic [PW-1:0] alu_slot;

   // Space is judged on the registered count only; the head leaving this
   // cycle does not make room for an incoming result.
   assign mem_ready = (count_q != CW'(DEPTH));
   assign mem_push  = mem_valid && mem_ready && (mem_dest != 5'd0);
   // The ALU needs a second free slot whenever mem is actually enqueueing.
   assign alu_ready = mem_push ? (count_q <= CW'(DEPTH - 2))
                               : (count_q <= CW'(DEPTH - 1));
   // Writes to x0 are handshaken but dropped.
   assign alu_push  = alu_valid && alu_ready && (alu_dest != 5'd0);

   assign pop      = (count_q != '0);
   assign alu_slot = tail_q + PW'(mem_push);

   assign rf_load = pop;
   assign rf_dest = pop ? dest_q[head_q] : 5'd0;
   assign rf_in   = pop ? data_q[head_q] : 32'd0;
   assign count   = count_q;

   always_comb begin
      head_d  = pop ? head_q + PW'(1) : head_q;
      tail_d  = tail_q + PW'(mem_push) + PW'(alu_push);
      count_d = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage needs no reset: occupancy is defined by count/head alone.
   always_ff @(posedge clk) begin
      if (mem_push) begin
         dest_q[tail_q] <= mem_dest;
         data_q[tail_q] <= mem_data;
      end
      if (alu_push) begin
         dest_q[alu_slot] <= alu_dest;
         data_q[alu_slot] <= alu_data;
      end
   end

   // Walk occupied entries oldest to youngest so the last match (youngest)
   // is the one left on the outputs.
   always_comb begin
      logic [PW-1:0] idx;
      idx        = '0;
      fwd_a_hit  = 1'b0;
      fwd_a_data = 32'd0;
      fwd_b_hit  = 1'b0;
      fwd_b_data = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q) begin
            if ((src_a != 5'd0) && (dest_q[idx] == src_a)) begin
               fwd_a_hit  = 1'b1;
               fwd_a_data = data_q[idx];
            end
            if ((src_b != 5'd0) && (dest_q[idx] == src_b)) begin
               fwd_b_hit  = 1'b1;
               fwd_b_data = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
module tb_rf_writeback_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, alu_valid;
   logic [4:0]  mem_dest, alu_dest, src_a, src_b;
   logic [31:0] mem_data, alu_data;
   logic        mem_ready, alu_ready, rf_load;
   logic [4:0]  rf_dest;
   logic [31:0] rf_in;
   logic        fwd_a_hit, fwd_b_hit;
   logic [31:0] fwd_a_data, fwd_b_data;
   logic [$clog2(DEPTH):0] count;

   rf_writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
      .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in),
      .src_a(src_a), .src_b(src_b),
      .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
      .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
   } entry_t;

   entry_t sb[$];
   int checks = 0;
   int errors = 0;
   logic exp_mpush, exp_apush;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fwd_model(input logic [4:0] src, output logic hit, output logic [31:0] data);
      hit  = 1'b0;
      data = 32'd0;
      if (src != 5'd0)
         foreach (sb[i])
            if (sb[i].dest == src) begin
               hit  = 1'b1;
               data = sb[i].data;
            end
   endtask

   // Compare every output against the scoreboard model, and decide which
   // pushes the model expects at the coming edge.
   task automatic check_all();
      logic mrdy, ardy, ha, hb;
      logic [31:0] da, db;
      int free;
      free = DEPTH - sb.size();
      mrdy = (free >= 1);
      exp_mpush = mem_valid && mrdy && (mem_dest != 5'd0);
      ardy = (free >= 1 + int'(exp_mpush));
      exp_apush = alu_valid && ardy && (alu_dest != 5'd0);
      chk("count", 32'(count), 32'(sb.size()));
      chk("mem_ready", 32'(mem_ready), 32'(mrdy));
      chk("alu_ready", 32'(alu_ready), 32'(ardy));
      chk("rf_load", 32'(rf_load), 32'(sb.size() > 0));
      chk("rf_dest", 32'(rf_dest), sb.size() > 0 ? 32'(sb[0].dest) : 32'd0);
      chk("rf_in", rf_in, sb.size() > 0 ? sb[0].data : 32'd0);
      fwd_model(src_a, ha, da);
      fwd_model(src_b, hb, db);
      chk("fwd_a_hit", 32'(fwd_a_hit), 32'(ha));
      chk("fwd_a_data", fwd_a_data, da);
      chk("fwd_b_hit", 32'(fwd_b_hit), 32'(hb));
      chk("fwd_b_data", fwd_b_data, db);
   endtask

   task automatic step();
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (sb.size() > 0) void'(sb.pop_front());
      if (exp_mpush) sb.push_back({mem_dest, mem_data});
      if (exp_apush) sb.push_back({alu_dest, alu_data});
      #1;
   endtask

   task automatic drive(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                        input logic av, input logic [4:0] ad, input logic [31:0] adat);
      mem_valid = mv; mem_dest = md; mem_data = mdat;
      alu_valid = av; alu_dest = ad; alu_data = adat;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      src_a = 5'd5;
      src_b = 5'd4;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_rf_load", 32'(rf_load), 32'd0);
      chk("rst_mem_ready", 32'(mem_ready), 32'd1);
      chk("rst_alu_ready", 32'(alu_ready), 32'd1);
      rst = 1'b0;
      step();

      // Single ALU write x5=0x1234, then two idle cycles to see it drain.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
      step();
      idle();
      chk("single_rf_load", 32'(rf_load), 32'd1);
      chk("single_rf_dest", 32'(rf_dest), 32'd5);
      chk("single_rf_in", rf_in, 32'h1234);
      chk("single_fwd_head", fwd_a_data, 32'h1234);
      step();
      chk("single_done", 32'(rf_load), 32'd0);
      step();

      // Same-cycle mem x3 / ALU x4 from empty: x3 written first.
      src_a = 5'd3;
      drive(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
      step();
      idle();
      chk("pair_count", 32'(count), 32'd2);
      chk("pair_first", 32'(rf_dest), 32'd3);
      step();
      chk("pair_second", 32'(rf_dest), 32'd4);
      step();
      step();

      // Hold both valids: the queue saturates at DEPTH-1 with a pop every
      // cycle, where mem is taken and the ALU is held off.
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 5'(10 + k), 32'(32'h100 + k), 1'b1, 5'(20 + k), 32'(32'h200 + k));
         src_a = 5'(10 + k);
         src_b = 5'(20 + k);
         step();
      end
      chk("sat_count", 32'(count), 32'd3);
      chk("sat_alu_stall", 32'(alu_ready), 32'd0);
      chk("sat_mem_ok", 32'(mem_ready), 32'd1);
      idle();
      repeat (4) step();

      // Two writes to x7: forwarding returns the younger value.
      drive(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
      src_a = 5'd7;
      src_b = 5'd0;
      step();
      idle();
      chk("fwd7_hit", 32'(fwd_a_hit), 32'd1);
      chk("fwd7_data", fwd_a_data, 32'h2);
      chk("fwd0_hit", 32'(fwd_b_hit), 32'd0);
      chk("fwd0_data", fwd_b_data, 32'd0);
      step();
      chk("fwd7_after_pop", fwd_a_data, 32'h2);
      step();
      step();

      // Build count=3, then mem to x0 alongside ALU x9 at count=DEPTH-1.
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
      step();
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      step();
      chk("x0_pre_count", 32'(count), 32'd3);
      drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd9, 32'h99);
      src_a = 5'd9;
      src_b = 5'd0;
      step();
      idle();
      chk("x0_count", 32'(count), 32'd3);
      chk("x9_fwd", fwd_a_data, 32'h99);
      step();

      // Asynchronous reset mid-drain at count=3.
      drive(1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13);
      step();
      idle();
      chk("mid_pre_count", 32'(count), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_rf_load", 32'(rf_load), 32'd0);
      chk("mid_rst_fwd", 32'(fwd_a_hit), 32'd0);
      chk("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Short pseudo-random run against the model.
      for (int k = 0; k < 40; k++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         src_a = 5'($urandom_range(0, 7));
         src_b = 5'($urandom_range(0, 7));
         step();
      end
      idle();
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
